pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch unit.
// Runs a three-state fetch loop: FETCH presents PC to instruction memory,
// WAIT captures the returned word, and HOLD presents it to the control FSM
// until that FSM asks for the next PC.
//
// Handshake: InstrValid is a level, not a pulse. Whenever InstrValid=1,
// Instr is stable and may be decoded. PCEn is honoured only while
// InstrValid=1 (state HOLD). It is ignored in FETCH and WAIT, and no request
// made there is remembered for later.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PCEn,
    input  logic [1:0]  PCState,
    input  logic        CondOut,
    input  logic [7:0]  Disp,
    input  logic [15:0] RTarget,
    input  logic [15:0] MemData,
    output logic [15:0] MemAddr,
    output logic [15:0] Instr,
    output logic        InstrValid,
    output logic [15:0] PC,
    output logic [15:0] LinkAddr,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] instr_q;
    logic        pc_load;
    logic        instr_load;
    logic        instr_valid;
    logic [15:0] pc_inc;
    logic [15:0] disp_sext;

    // Sequential successor and sign-extended displacement; both wrap mod 2^16.
    always_comb begin
        pc_inc    = pc_q + 16'd1;
        disp_sext = {{8{Disp[7]}}, Disp};
    end

    // Next-PC selection; only applied when the FSM grants an advance from HOLD.
    always_comb begin
        pc_d = pc_inc;
        case (PCState)
            PCS_SEQ:    pc_d = pc_inc;
            PCS_BRANCH: pc_d = CondOut ? (pc_q + disp_sext) : pc_inc;
            PCS_JUMP:   pc_d = CondOut ? RTarget : pc_inc;
            default:    pc_d = pc_q;   // hold mode refetches the same address
        endcase
    end

    // Fetch FSM next-state and control strobes.
    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        instr_load  = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                instr_load = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (PCEn) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;   // unreachable encoding recovers to a fresh fetch
        endcase
    end

    // State register; reset restarts fetching at RESET_VECTOR.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter; advances only on a granted request from HOLD.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (pc_load) begin
            pc_q <= pc_d;
        end
    end

    // Instruction register; loads only on the WAIT->HOLD edge, so a reset mid-fetch drops the word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instr_q <= 16'h0000;
        end else if (instr_load) begin
            instr_q <= MemData;
        end
    end

    // Output drive; MemAddr tracks PC in every state.
    always_comb begin
        MemAddr    = pc_q;
        PC         = pc_q;
        LinkAddr   = pc_inc;
        Instr      = instr_q;
        InstrValid = instr_valid;
        fsm_state  = state_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed cases followed by random
// PC-advance requests, checked against a next-PC model derived from the
// branch/jump rules and a hashed instruction memory.
module tb_pc_fetch_unit;

    localparam logic [15:0] RV = 16'h0000;

    logic        Clk;
    logic        Rst_n;
    logic        PCEn;
    logic [1:0]  PCState;
    logic        CondOut;
    logic [7:0]  Disp;
    logic [15:0] RTarget;
    logic [15:0] MemData;
    logic [15:0] MemAddr;
    logic [15:0] Instr;
    logic        InstrValid;
    logic [15:0] PC;
    logic [15:0] LinkAddr;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_pc;
    logic [15:0] model_instr;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PCEn(PCEn), .PCState(PCState),
        .CondOut(CondOut), .Disp(Disp), .RTarget(RTarget), .MemData(MemData),
        .MemAddr(MemAddr), .Instr(Instr), .InstrValid(InstrValid), .PC(PC),
        .LinkAddr(LinkAddr), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Instruction memory contents: fixed word at 0, hashed elsewhere.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] t;
        t = {16'h0, a} * 32'h9E37 + 32'h1234;
        return (a == 16'h0000) ? 16'h5103 : (t[15:0] ^ {a[7:0], a[15:8]});
    endfunction

    // Synchronous-read memory: data valid one cycle after the address.
    always @(posedge Clk) MemData <= mem_word(MemAddr);

    // Reference next PC, computed with integer arithmetic then wrapped.
    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [1:0] mode,
                                               input logic cond, input logic [7:0] d,
                                               input logic [15:0] tgt);
        int v;
        case (mode)
            2'd0: v = int'(pc) + 1;
            2'd1: v = cond ? int'(pc) + int'($signed(d)) : int'(pc) + 1;
            2'd2: v = cond ? int'(tgt) : int'(pc) + 1;
            default: v = int'(pc);
        endcase
        v = v & 32'hFFFF;
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Caller is at a negedge with the DUT in HOLD.
    task automatic do_step(input logic [1:0] mode, input logic cond, input logic [7:0] d,
                           input logic [15:0] tgt, input bit keep_en);
        logic [15:0] exp_pc;
        exp_pc = model_next(model_pc, mode, cond, d, tgt);
        PCEn = 1'b1; PCState = mode; CondOut = cond; Disp = d; RTarget = tgt;
        exp_q.push_back(mem_word(exp_pc));
        @(negedge Clk);
        if (!keep_en) PCEn = 1'b0;
        PCState = 2'($urandom_range(0, 3));   // must not matter outside HOLD
        CondOut = 1'($urandom_range(0, 1));
        check("fetch_valid", 16'(InstrValid), 16'd0);
        check("fetch_pc", PC, exp_pc);
        check("fetch_addr", MemAddr, exp_pc);
        check("fetch_instr", Instr, model_instr);
        @(negedge Clk);
        check("wait_valid", 16'(InstrValid), 16'd0);
        check("wait_pc", PC, exp_pc);
        check("wait_instr", Instr, model_instr);
        @(negedge Clk);
        check("hold_valid", 16'(InstrValid), 16'd1);
        check("hold_pc", PC, exp_pc);
        check("hold_link", LinkAddr, exp_pc + 16'd1);
        check("hold_instr", Instr, exp_q.pop_front());
        model_pc    = exp_pc;
        model_instr = mem_word(exp_pc);
    endtask

    task automatic do_idle();
        PCEn = 1'b0;
        PCState = 2'($urandom_range(0, 3));
        @(negedge Clk);
        check("idle_valid", 16'(InstrValid), 16'd1);
        check("idle_pc", PC, model_pc);
        check("idle_instr", Instr, model_instr);
    endtask

    task automatic reset_release_check();
        Rst_n = 1'b1;
        model_pc = RV;
        model_instr = mem_word(RV);
        @(negedge Clk);
        check("rel1_valid", 16'(InstrValid), 16'd0);
        check("rel1_instr", Instr, 16'h0000);
        @(negedge Clk);
        check("rel2_valid", 16'(InstrValid), 16'd1);
        check("rel2_instr", Instr, mem_word(RV));
        check("rel2_pc", PC, RV);
        check("rel2_link", LinkAddr, RV + 16'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        Rst_n = 1'b0; PCEn = 1'b0; PCState = 2'd0; CondOut = 1'b0;
        Disp = 8'h00; RTarget = 16'h0000; MemData = 16'h0000;
        model_pc = RV; model_instr = 16'h0000;
        repeat (2) @(negedge Clk);
        check("rst_pc", PC, RV);
        check("rst_valid", 16'(InstrValid), 16'd0);
        check("rst_instr", Instr, 16'h0000);
        reset_release_check();

        // Branch taken/not taken from 0x0010.
        do_step(2'd2, 1'b1, 8'h00, 16'h0010, 1'b0);
        do_step(2'd1, 1'b1, 8'hFC, 16'h0000, 1'b0);
        check("br_taken", PC, 16'h000C);
        do_step(2'd2, 1'b1, 8'h00, 16'h0010, 1'b0);
        do_step(2'd1, 1'b0, 8'hFC, 16'h0000, 1'b0);
        check("br_not_taken", PC, 16'h0011);
        // Jump taken/not taken from 0x0020.
        do_step(2'd2, 1'b1, 8'h00, 16'h0020, 1'b0);
        do_step(2'd2, 1'b1, 8'h00, 16'h1234, 1'b0);
        check("jmp_taken", PC, 16'h1234);
        do_step(2'd2, 1'b1, 8'h00, 16'h0020, 1'b0);
        do_step(2'd2, 1'b0, 8'h00, 16'h1234, 1'b0);
        check("jmp_not_taken", PC, 16'h0021);
        // Refetch and idle hold.
        do_step(2'd3, 1'b1, 8'h55, 16'hBEEF, 1'b0);
        do_idle();
        do_idle();
        // Wrap at 0xFFFF with PCEn held high across FETCH/WAIT.
        do_step(2'd2, 1'b1, 8'h00, 16'hFFFF, 1'b0);
        do_step(2'd0, 1'b0, 8'h00, 16'h0000, 1'b1);
        check("wrap", PC, 16'h0000);
        do_step(2'd0, 1'b0, 8'h00, 16'h0000, 1'b1);
        do_step(2'd0, 1'b0, 8'h00, 16'h0000, 1'b0);
        check("one_per_visit", PC, 16'h0002);

        // Asynchronous reset during WAIT.
        PCEn = 1'b1; PCState = 2'd2; CondOut = 1'b1; RTarget = 16'h4321;
        @(negedge Clk);
        PCEn = 1'b0;
        @(negedge Clk);
        check("pre_rst_state", 16'(fsm_state), 16'd1);
        #1 Rst_n = 1'b0;
        #1;
        check("async_pc", PC, RV);
        check("async_valid", 16'(InstrValid), 16'd0);
        check("async_instr", Instr, 16'h0000);
        @(negedge Clk);
        reset_release_check();

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_idle();
            end else begin
                do_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                        bit'($urandom_range(0, 1)));
            end
        end
        PCEn = 1'b0;
        check("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
